alu_issue_stage: RTL and testbench

// - Registered issue stage directly upstream of the ALU. Takes decoded ops from the decode stage,

---
 rtl/alu_issue_stage_if.sv | 41 ++++
 rtl/alu_issue_stage.sv | 154 +++++++++++++++
 tb/tb_alu_issue_stage.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_stage_if.sv
// Decode -> issue -> ALU handshake bundle for alu_issue_stage, plus the writeback forwarding source.
// master drives the decode/consumer/writeback side; slave is the issue stage itself.
interface alu_issue_stage_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_aluctl;
  logic [1:0]        in_a_sel;
  logic [1:0]        in_b_sel;
  logic [REG_AW-1:0] in_rs1;
  logic [REG_AW-1:0] in_rs2;
  logic [XLEN-1:0]   in_rs1_val;
  logic [XLEN-1:0]   in_rs2_val;
  logic [XLEN-1:0]   in_imm;
  logic [XLEN-1:0]   in_pc;
  logic [REG_AW-1:0] in_rd;
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        ALUCtl;
  logic [XLEN-1:0]   A;
  logic [XLEN-1:0]   B;
  logic [REG_AW-1:0] out_rd;
  logic              flush;
  logic              wb_we;
  logic [REG_AW-1:0] wb_rd;
  logic [XLEN-1:0]   wb_data;

  modport master (
    output in_valid, in_aluctl, in_a_sel, in_b_sel, in_rs1, in_rs2, in_rs1_val, in_rs2_val,
           in_imm, in_pc, in_rd, out_ready, flush, wb_we, wb_rd, wb_data,
    input  in_ready, out_valid, ALUCtl, A, B, out_rd
  );

  modport slave (
    input  in_valid, in_aluctl, in_a_sel, in_b_sel, in_rs1, in_rs2, in_rs1_val, in_rs2_val,
           in_imm, in_pc, in_rd, out_ready, flush, wb_we, wb_rd, wb_data,
    output in_ready, out_valid, ALUCtl, A, B, out_rd
  );
endinterface

// File: rtl/alu_issue_stage.sv
// Issue stage ahead of the ALU: 2-entry skid buffer (HEAD/SKID) and A/B operand selection.
// Optional writeback forwarding into buffered rs values is enabled by defining ALU_ISSUE_FWD_EN.
module alu_issue_stage #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input logic              clk,
  input logic              rst,
  alu_issue_stage_if.slave bus
);

  localparam int unsigned CTL_W = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [CTL_W-1:0]  aluctl;
    logic [SEL_W-1:0]  a_sel;
    logic [SEL_W-1:0]  b_sel;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [XLEN-1:0]   rs1_val;
    logic [XLEN-1:0]   rs2_val;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc;
    logic [REG_AW-1:0] rd;
  } entry_t;

  state_t state_q, state_d;
  entry_t head_q, head_d;
  entry_t skid_q, skid_d;
  entry_t cap_raw, cap_entry, head_fwd, skid_fwd;
  logic   accept, pop;
  logic [XLEN-1:0] a_val, b_val;

  assign accept = bus.in_valid & (state_q != TWO);
  assign pop    = bus.out_ready & (state_q != EMPTY);

  always_comb begin
    cap_raw         = '0;
    cap_raw.aluctl  = bus.in_aluctl;
    cap_raw.a_sel   = bus.in_a_sel;
    cap_raw.b_sel   = bus.in_b_sel;
    cap_raw.rs1     = bus.in_rs1;
    cap_raw.rs2     = bus.in_rs2;
    cap_raw.rs1_val = bus.in_rs1_val;
    cap_raw.rs2_val = bus.in_rs2_val;
    cap_raw.imm     = bus.in_imm;
    cap_raw.pc      = bus.in_pc;
    cap_raw.rd      = bus.in_rd;
  end

`ifdef ALU_ISSUE_FWD_EN
  // Replace rs values whose index matches a live writeback; x0 never forwards.
  function automatic entry_t fwd_entry(input entry_t e, input logic we,
                                       input logic [REG_AW-1:0] wrd, input logic [XLEN-1:0] wdata);
    entry_t r;
    r = e;
    if (we && (wrd != '0) && (e.rs1 == wrd)) r.rs1_val = wdata;
    if (we && (wrd != '0) && (e.rs2 == wrd)) r.rs2_val = wdata;
    return r;
  endfunction

  assign cap_entry = fwd_entry(cap_raw, bus.wb_we, bus.wb_rd, bus.wb_data);
  assign head_fwd  = fwd_entry(head_q,  bus.wb_we, bus.wb_rd, bus.wb_data);
  assign skid_fwd  = fwd_entry(skid_q,  bus.wb_we, bus.wb_rd, bus.wb_data);
`else
  logic unused_wb;
  assign unused_wb = ^{bus.wb_we, bus.wb_rd, bus.wb_data};
  assign cap_entry = cap_raw;
  assign head_fwd  = head_q;
  assign skid_fwd  = skid_q;
`endif

  // Next-state and entry update; flush overrides everything and leaves entries stale.
  always_comb begin
    state_d = state_q;
    head_d  = (state_q != EMPTY) ? head_fwd : head_q;
    skid_d  = (state_q == TWO)   ? skid_fwd : skid_q;
    if (bus.flush) begin
      state_d = EMPTY;
      head_d  = head_q;
      skid_d  = skid_q;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            head_d  = cap_entry;
          end
        end
        ONE: begin
          if (accept && pop) begin
            head_d = cap_entry;
          end else if (accept) begin
            state_d = TWO;
            skid_d  = cap_entry;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            state_d = ONE;
            head_d  = skid_fwd;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

  // Operand muxes straight off the stored head fields.
  always_comb begin
    a_val = '0;
    b_val = '0;
    unique case (head_q.a_sel)
      2'b00:   a_val = head_q.rs1_val;
      2'b01:   a_val = head_q.pc;
      default: a_val = '0;
    endcase
    unique case (head_q.b_sel)
      2'b00:   b_val = head_q.rs2_val;
      2'b01:   b_val = head_q.imm;
      2'b10:   b_val = XLEN'(4);
      default: b_val = '0;
    endcase
  end

  assign bus.in_ready  = (state_q != TWO);
  assign bus.out_valid = (state_q != EMPTY);
  assign bus.ALUCtl    = head_q.aluctl;
  assign bus.A         = a_val;
  assign bus.B         = b_val;
  assign bus.out_rd    = head_q.rd;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: operand table, hand-written stall/flush/forward/stream sequences,
// and randomized traffic against a queue-based reference model.
module tb_alu_issue_stage;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  logic clk;
  logic rst;

  alu_issue_stage_if #(.XLEN(XLEN), .REG_AW(REG_AW)) bus ();

  alu_issue_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  aluctl;
    logic [1:0]  a_sel;
    logic [1:0]  b_sel;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  rd;
  } op_t;

  typedef struct {
    logic [3:0]  aluctl;
    logic [1:0]  a_sel;
    logic [1:0]  b_sel;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  op_t        mq[$];
  logic [4:0] popped[$];
  int         checks;
  int         failures;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_a(input op_t o);
    if (o.a_sel == 2'b00) return o.rs1_val;
    if (o.a_sel == 2'b01) return o.pc;
    return 32'd0;
  endfunction

  function automatic logic [31:0] model_b(input op_t o);
    if (o.b_sel == 2'b00) return o.rs2_val;
    if (o.b_sel == 2'b01) return o.imm;
    if (o.b_sel == 2'b10) return 32'd4;
    return 32'd0;
  endfunction

  function automatic op_t cur_op();
    op_t o;
    o.aluctl  = bus.in_aluctl;
    o.a_sel   = bus.in_a_sel;
    o.b_sel   = bus.in_b_sel;
    o.rs1     = bus.in_rs1;
    o.rs2     = bus.in_rs2;
    o.rs1_val = bus.in_rs1_val;
    o.rs2_val = bus.in_rs2_val;
    o.imm     = bus.in_imm;
    o.pc      = bus.in_pc;
    o.rd      = bus.in_rd;
    return o;
  endfunction

  task automatic idle_inputs();
    bus.in_valid   = 1'b0;
    bus.in_aluctl  = 4'd0;
    bus.in_a_sel   = 2'd0;
    bus.in_b_sel   = 2'd0;
    bus.in_rs1     = 5'd0;
    bus.in_rs2     = 5'd0;
    bus.in_rs1_val = 32'd0;
    bus.in_rs2_val = 32'd0;
    bus.in_imm     = 32'd0;
    bus.in_pc      = 32'd0;
    bus.in_rd      = 5'd0;
    bus.out_ready  = 1'b0;
    bus.flush      = 1'b0;
    bus.wb_we      = 1'b0;
    bus.wb_rd      = 5'd0;
    bus.wb_data    = 32'd0;
  endtask

  // One clock: advance the queue model with the current inputs, then compare the DUT to it.
  task automatic tick();
    op_t n;
    bit  acc;
    bit  pop;
    n   = cur_op();
    acc = bus.in_valid && (mq.size() < 2);
    pop = bus.out_ready && (mq.size() > 0);
    if (bus.out_valid && bus.out_ready) popped.push_back(bus.out_rd);
`ifdef ALU_ISSUE_FWD_EN
    if (bus.wb_we && bus.wb_rd != 5'd0) begin
      foreach (mq[i]) begin
        if (mq[i].rs1 == bus.wb_rd) mq[i].rs1_val = bus.wb_data;
        if (mq[i].rs2 == bus.wb_rd) mq[i].rs2_val = bus.wb_data;
      end
      if (n.rs1 == bus.wb_rd) n.rs1_val = bus.wb_data;
      if (n.rs2 == bus.wb_rd) n.rs2_val = bus.wb_data;
    end
`endif
    @(posedge clk);
    if (rst || bus.flush) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back(n);
    end
    #1;
    chk("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
    chk("in_ready", 32'(bus.in_ready), 32'(mq.size() < 2));
    if (mq.size() != 0) begin
      chk("ALUCtl", 32'(bus.ALUCtl), 32'(mq[0].aluctl));
      chk("A", bus.A, model_a(mq[0]));
      chk("B", bus.B, model_b(mq[0]));
      chk("out_rd", 32'(bus.out_rd), 32'(mq[0].rd));
    end
  endtask

  task automatic drain();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b1;
    tick();
    bus.flush    = 1'b0;
  endtask

  vec_t vt[6];
  int   ir_low;

  initial begin
    checks   = 0;
    failures = 0;
    idle_inputs();
    rst = 1'b1;

    vt[0] = '{4'b0010, 2'b00, 2'b01, 32'd5,         32'd99,        32'd7,         32'h40,        5'd1, 32'd5,         32'd7};
    vt[1] = '{4'b0110, 2'b01, 2'b10, 32'd1,         32'd2,         32'd3,         32'h100,       5'd2, 32'h100,       32'd4};
    vt[2] = '{4'b0111, 2'b11, 2'b00, 32'd11,        32'd22,        32'd33,        32'd44,        5'd3, 32'd0,         32'd22};
    vt[3] = '{4'b0001, 2'b10, 2'b11, 32'd55,        32'd66,        32'd77,        32'd88,        5'd4, 32'd0,         32'd0};
    vt[4] = '{4'b0000, 2'b00, 2'b00, 32'hDEADBEEF,  32'h12345678,  32'd1,         32'd2,         5'd5, 32'hDEADBEEF,  32'h12345678};
    vt[5] = '{4'b1100, 2'b01, 2'b01, 32'd9,         32'd9,         32'hFFFFFFFC,  32'hFFFFFFF0,  5'd31, 32'hFFFFFFF0, 32'hFFFFFFFC};

    tick();
    rst = 1'b0;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_ALUCtl", 32'(bus.ALUCtl), 32'd0);
    chk("rst_A", bus.A, 32'd0);
    chk("rst_B", bus.B, 32'd0);
    chk("rst_out_rd", 32'(bus.out_rd), 32'd0);

    // Operand-forming table: each op in, visible next cycle, popped the cycle after.
    bus.out_ready = 1'b1;
    foreach (vt[i]) begin
      bus.in_valid   = 1'b1;
      bus.in_aluctl  = vt[i].aluctl;
      bus.in_a_sel   = vt[i].a_sel;
      bus.in_b_sel   = vt[i].b_sel;
      bus.in_rs1_val = vt[i].rs1_val;
      bus.in_rs2_val = vt[i].rs2_val;
      bus.in_imm     = vt[i].imm;
      bus.in_pc      = vt[i].pc;
      bus.in_rd      = vt[i].rd;
      tick();
      bus.in_valid = 1'b0;
      chk("vec_valid", 32'(bus.out_valid), 32'd1);
      chk("vec_ALUCtl", 32'(bus.ALUCtl), 32'(vt[i].aluctl));
      chk("vec_A", bus.A, vt[i].exp_a);
      chk("vec_B", bus.B, vt[i].exp_b);
      chk("vec_rd", 32'(bus.out_rd), 32'(vt[i].rd));
      tick();
      chk("vec_popped", 32'(bus.out_valid), 32'd0);
    end

    // Stall with three pushes, then release: order 11,12,13.
    popped.delete();
    idle_inputs();
    bus.in_valid = 1'b1;
    bus.in_rd = 5'd11; tick();
    bus.in_rd = 5'd12; tick();
    chk("two_in_ready", 32'(bus.in_ready), 32'd0);
    bus.in_rd = 5'd13; tick();
    chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    tick();
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    chk("order_count", 32'(popped.size()), 32'd3);
    if (popped.size() == 3) begin
      chk("order_0", 32'(popped[0]), 32'd11);
      chk("order_1", 32'(popped[1]), 32'd12);
      chk("order_2", 32'(popped[2]), 32'd13);
    end

    // Flush in TWO and in ONE with a concurrent op: nothing survives.
    popped.delete();
    idle_inputs();
    bus.in_valid = 1'b1;
    bus.in_rd = 5'd21; tick();
    bus.in_rd = 5'd22; tick();
    bus.in_rd = 5'd23; bus.flush = 1'b1; bus.out_ready = 1'b1; tick();
    chk("flush2_out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush2_in_ready", 32'(bus.in_ready), 32'd1);
    bus.flush = 1'b0; bus.out_ready = 1'b0;
    bus.in_rd = 5'd24; tick();
    bus.in_rd = 5'd25; bus.flush = 1'b1; tick();
    chk("flush1_out_valid", 32'(bus.out_valid), 32'd0);
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    tick();
    tick();
    chk("flush_no_ghost", 32'(popped.size()), 32'd1);

    // Writeback forwarding into a stalled HEAD.
    idle_inputs();
    bus.in_valid = 1'b1; bus.in_rs1 = 5'd3; bus.in_rs1_val = 32'd1;
    tick();
    bus.in_valid = 1'b0; bus.wb_we = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 32'hAA;
    tick();
`ifdef ALU_ISSUE_FWD_EN
    chk("fwd_rs1", bus.A, 32'hAA);
`else
    chk("nofwd_rs1", bus.A, 32'd1);
`endif
    bus.wb_we = 1'b0;
    drain();
    bus.in_valid = 1'b1; bus.in_rs1 = 5'd0; bus.in_rs1_val = 32'd1;
    tick();
    bus.in_valid = 1'b0; bus.wb_we = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'hAA;
    tick();
    chk("fwd_x0", bus.A, 32'd1);
    bus.wb_we = 1'b0;
    drain();

    // Streaming: 100 back-to-back ops.
    idle_inputs();
    popped.delete();
    ir_low = 0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 101; i++) begin
      bus.in_valid = (i < 100);
      bus.in_rd    = 5'(i);
      if (!bus.in_ready) ir_low++;
      tick();
    end
    chk("stream_pops", 32'(popped.size()), 32'd100);
    chk("stream_in_ready", 32'(ir_low), 32'd0);
    if (popped.size() == 100) chk("stream_last_rd", 32'(popped[99]), 32'(5'(99)));

    // Randomized traffic against the model.
    idle_inputs();
    for (int c = 0; c < 3000; c++) begin
      bus.in_valid   = ($urandom % 4) != 0;
      bus.in_aluctl  = 4'($urandom);
      bus.in_a_sel   = 2'($urandom);
      bus.in_b_sel   = 2'($urandom);
      bus.in_rs1     = 5'($urandom_range(0, 7));
      bus.in_rs2     = 5'($urandom_range(0, 7));
      bus.in_rs1_val = $urandom;
      bus.in_rs2_val = $urandom;
      bus.in_imm     = $urandom;
      bus.in_pc      = $urandom;
      bus.in_rd      = 5'($urandom);
      bus.out_ready  = ($urandom % 3) != 0;
      bus.flush      = ($urandom % 40) == 0;
      bus.wb_we      = ($urandom % 2) != 0;
      bus.wb_rd      = 5'($urandom_range(0, 7));
      bus.wb_data    = $urandom;
      rst            = ($urandom % 200) == 0;
      tick();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
